gbtx_link_sequencer: RTL

GBTX_LINK_SEQUENCER -- requirements
Module: gbtx_link_sequencer

---
 rtl/gefe_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/gbtx_link_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gefe_pkg.sv
// Shared definitions for the GBTx link sequencer: state codes, default
// timing parameters and small counter helpers.
package gefe_pkg;

   localparam int RST_CYCLES_DEF  = 400;
   localparam int RDY_TIMEOUT_DEF = 1048576;
   localparam int DV_STABLE_DEF   = 1024;
   localparam int MAX_RETRY_DEF   = 8;

   typedef enum logic [2:0] {
      ST_RESET      = 3'd0,
      ST_WAIT_TXRDY = 3'd1,
      ST_WAIT_RXRDY = 3'd2,
      ST_WAIT_DV    = 3'd3,
      ST_LINK_UP    = 3'd4,
      ST_LOS_HOLD   = 3'd5,
      ST_FAULT      = 3'd6
   } state_t;

   // Bits needed to hold the values 0..n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gbtx_link_sequencer.sv
// GBTx link bring-up sequencer: reset pulse, ready/valid handshakes with
// timeouts and retry limit, LOS hold-off and link-loss accounting.
module gbtx_link_sequencer
   import gefe_pkg::*;
#(
   parameter int RST_CYCLES  = RST_CYCLES_DEF,
   parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF,
   parameter int DV_STABLE   = DV_STABLE_DEF,
   parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
   input  logic        GbtxElinksDclkCg_ik,
   input  logic        GeneralReset_iran,
   input  logic        OptoLosReset_iran,
   input  logic        GbtxTxRdy_i,
   input  logic        GbtxRxRdy_i,
   input  logic        GbtxRxDataValid_i,
   input  logic        Restart_i,
   output logic        GbtxReset_or,
   output logic        GbtxTxDataValid_o,
   output logic        LinkUp_o,
   output logic        Fault_o,
   output logic [2:0]  State_ob3,
   output logic [3:0]  RetryCnt_ob4,
   output logic [15:0] LossCnt_ob16
);

   localparam int TMR_MAX = (RST_CYCLES > RDY_TIMEOUT) ? RST_CYCLES : RDY_TIMEOUT;
   localparam int TW      = cnt_w(TMR_MAX);
   localparam int DW      = cnt_w(DV_STABLE);

   logic clk, rst_n;
   assign clk   = GbtxElinksDclkCg_ik;
   assign rst_n = GeneralReset_iran;

   logic [3:0] raw, syn;
   logic       opto_ok, tx_rdy, rx_rdy, rx_dv;

   assign raw = {OptoLosReset_iran, GbtxTxRdy_i, GbtxRxRdy_i, GbtxRxDataValid_i};

   for (genvar i = 0; i < 4; i++) begin : g_sync
      sync_2ff u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (raw[i]),
         .q     (syn[i])
      );
   end

   assign {opto_ok, tx_rdy, rx_rdy, rx_dv} = syn;

   state_t          state, state_nxt;
   logic [TW-1:0]   tmr;
   logic [DW-1:0]   dv_cnt;
   logic [3:0]      retry, retry_nxt;
   logic [15:0]     loss, loss_nxt;
   logic            entry, to_hit;
   logic            tmo, rst_done, dv_done;

   assign tmo      = (tmr == TW'(RDY_TIMEOUT - 1));
   assign rst_done = (tmr == TW'(RST_CYCLES - 1));
   assign dv_done  = rx_dv && (dv_cnt == DW'(DV_STABLE - 1));

   always_comb begin
      state_nxt = state;
      retry_nxt = retry;
      loss_nxt  = loss;
      to_hit    = 1'b0;
      entry     = 1'b0;

      case (state)
         ST_RESET:      if (rst_done) state_nxt = ST_WAIT_TXRDY;
         ST_WAIT_TXRDY: if (tx_rdy) state_nxt = ST_WAIT_RXRDY; else to_hit = tmo;
         ST_WAIT_RXRDY: if (rx_rdy) state_nxt = ST_WAIT_DV;    else to_hit = tmo;
         ST_WAIT_DV:    if (dv_done) state_nxt = ST_LINK_UP;   else to_hit = tmo;
         ST_LINK_UP: begin
            if (!tx_rdy || !rx_rdy || !rx_dv) begin
               state_nxt = ST_RESET;
               loss_nxt  = sat_inc16(loss);
            end
         end
         ST_LOS_HOLD:   if (opto_ok) state_nxt = ST_RESET;
         ST_FAULT:      state_nxt = ST_FAULT;
         default:       state_nxt = ST_RESET;
      endcase

      if (to_hit) begin
         retry_nxt = retry + 4'd1;
         state_nxt = (retry_nxt == 4'(MAX_RETRY)) ? ST_FAULT : ST_RESET;
      end

      if (state_nxt == ST_LINK_UP && state != ST_LINK_UP)
         retry_nxt = 4'd0;

      // LOS discards whatever the handshake logic decided this cycle.
      if (!opto_ok && state != ST_FAULT) begin
         state_nxt = ST_LOS_HOLD;
         retry_nxt = retry;
         loss_nxt  = (state == ST_LINK_UP) ? sat_inc16(loss) : loss;
      end

      // Restart counts as a fresh RESET entry even when already in RESET.
      if (Restart_i) begin
         state_nxt = ST_RESET;
         retry_nxt = 4'd0;
         loss_nxt  = loss;
         entry     = 1'b1;
      end

      if (state_nxt != state)
         entry = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_RESET;
         tmr    <= '0;
         dv_cnt <= '0;
         retry  <= 4'd0;
         loss   <= 16'd0;
      end else begin
         state <= state_nxt;
         retry <= retry_nxt;
         loss  <= loss_nxt;
         if (entry)
            tmr <= '0;
         else if (tmr != {TW{1'b1}})
            tmr <= tmr + 1'b1;
         if (entry || !rx_dv)
            dv_cnt <= '0;
         else if (state == ST_WAIT_DV)
            dv_cnt <= dv_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         GbtxReset_or      <= 1'b1;
         GbtxTxDataValid_o <= 1'b0;
         LinkUp_o          <= 1'b0;
         Fault_o           <= 1'b0;
         State_ob3         <= 3'd0;
         RetryCnt_ob4      <= 4'd0;
         LossCnt_ob16      <= 16'd0;
      end else begin
         GbtxReset_or      <= (state == ST_RESET) || (state == ST_LOS_HOLD);
         GbtxTxDataValid_o <= (state == ST_LINK_UP);
         LinkUp_o          <= (state == ST_LINK_UP);
         Fault_o           <= (state == ST_FAULT);
         State_ob3         <= state;
         RetryCnt_ob4      <= retry;
         LossCnt_ob16      <= loss;
      end
   end

endmodule
